// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
// Optional timeout logic is compiled in with APB_ARB_TIMEOUT_EN.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_e;

  localparam int unsigned APB_ARB_NB_REQ = 2;

  // Counter width able to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle shared between the arbiter (Master) and the peripheral decoder (Slave).
interface APB_BUS #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_master_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module apb_rr_picker #(
  parameter int unsigned NB_REQ = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NB_REQ-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NB_REQ-1:0] onehot,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  int unsigned k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int unsigned i = 1; i <= NB_REQ; i++) begin
      k = (int'(last) + i) % NB_REQ;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        onehot[k] = 1'b1;
        idx       = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NB_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NB_REQ         = APB_ARB_NB_REQ,
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NB_REQ-1:0]                  req_we_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                               rsp_err_o,
  APB_BUS.Master                             apb_master
);

  localparam int unsigned IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam logic [1:0]  S_IDLE   = IDLE;
  localparam logic [1:0]  S_SETUP  = SETUP;
  localparam logic [1:0]  S_ACCESS = ACCESS;

  logic [1:0]                state_q, state_d;
  logic [IDX_W-1:0]          last_q, last_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic [NB_REQ-1:0]         rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  logic [NB_REQ-1:0]         pick_onehot;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_valid;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = tmo_cnt_width(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] cnt_q, cnt_d;
`endif

  apb_rr_picker #(
    .NB_REQ (NB_REQ),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req    (req_i),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // Next-state, capture and response logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    gnt_o       = '0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          gnt_o    = pick_onehot;
          last_d   = pick_idx;
          owner_d  = pick_idx;
          paddr_d  = req_addr_i[int'(pick_idx)*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
          pwdata_d = req_wdata_i[int'(pick_idx)*APB_DATA_WIDTH +: APB_DATA_WIDTH];
          pwrite_d = req_we_i[pick_idx];
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_ACCESS: begin
        // pready takes precedence over a timeout reached in the same cycle.
        if (apb_master.pready) begin
          state_d     = S_IDLE;
          rsp_valid_d = NB_REQ'(1) << owner_q;
          rsp_rdata_d = pwrite_q ? '0 : apb_master.prdata;
          rsp_err_d   = apb_master.pslverr;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_IDLE;
          rsp_valid_d = NB_REQ'(1) << owner_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    psel_d    = (state_d != S_IDLE);
    penable_d = (state_d == S_ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= IDX_W'(NB_REQ - 1);
      owner_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign apb_master.paddr   = paddr_q;
  assign apb_master.pwdata  = pwdata_q;
  assign apb_master.pwrite  = pwrite_q;
  assign apb_master.psel    = psel_q;
  assign apb_master.penable = penable_q;
  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_rdata_o        = rsp_rdata_q;
  assign rsp_err_o          = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; timeout steps run when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;

  localparam int unsigned NB  = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [NB-1:0]   req_i;
  logic [NB*AW-1:0] req_addr_i;
  logic [NB-1:0]   req_we_i;
  logic [NB*DW-1:0] req_wdata_i;
  logic [NB-1:0]   gnt_o;
  logic [NB-1:0]   rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;

  int passed = 0;
  int total  = 0;

  APB_BUS #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();

  apb_master_arbiter #(
    .NB_REQ         (NB),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .gnt_o       (gnt_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .apb_master  (apb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cy();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_i = '0; req_addr_i = '0; req_we_i = '0; req_wdata_i = '0;
    apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;
    cy(); cy(); #1;
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_rdata", 64'(rsp_rdata_o), 64'h0);
    chk("rst_err", 64'(rsp_err_o), 64'h0);
    chk("rst_paddr", 64'(apb.paddr), 64'h0);
    chk("rst_pwdata", 64'(apb.pwdata), 64'h0);
    chk("rst_psel_pen_pwr", 64'({apb.psel, apb.penable, apb.pwrite}), 64'h0);
    rst = 1'b0;

    // Zero-wait read from requester 0.
    cy(); req_i = 2'b01; req_addr_i[31:0] = 32'h1A10_1000; req_we_i = 2'b00; #1;
    chk("t1_gnt", 64'(gnt_o), 64'h1);
    chk("t1_c0_psel", 64'(apb.psel), 64'h0);
    cy(); req_i = 2'b00; apb.pready = 1'b1; apb.prdata = 32'hDEAD_BEEF; #1;
    chk("t1_setup_sel_en", 64'({apb.psel, apb.penable}), 64'h2);
    chk("t1_setup_paddr", 64'(apb.paddr), 64'h1A10_1000);
    chk("t1_setup_pwrite", 64'(apb.pwrite), 64'h0);
    cy(); #1;
    chk("t1_access_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); apb.pready = 1'b0; #1;
    chk("t1_rsp_valid", 64'(rsp_valid_o), 64'h1);
    chk("t1_rdata", 64'(rsp_rdata_o), 64'hDEAD_BEEF);
    chk("t1_err", 64'(rsp_err_o), 64'h0);
    chk("t1_idle_sel_en", 64'({apb.psel, apb.penable}), 64'h0);
    chk("t1_idle_paddr_hold", 64'(apb.paddr), 64'h1A10_1000);
    cy(); #1;
    chk("t1_rsp_pulse_end", 64'(rsp_valid_o), 64'h0);
    chk("t1_rdata_hold", 64'(rsp_rdata_o), 64'hDEAD_BEEF);

    // Write from requester 1, three wait states, slave error.
    cy(); req_i = 2'b10; req_addr_i[63:32] = 32'h1A10_2000; req_we_i = 2'b10;
    req_wdata_i[63:32] = 32'h1234_5678; #1;
    chk("t2_gnt", 64'(gnt_o), 64'h2);
    cy(); req_i = 2'b00; #1;
    chk("t2_setup_pwrite", 64'(apb.pwrite), 64'h1);
    chk("t2_setup_pwdata", 64'(apb.pwdata), 64'h1234_5678);
    chk("t2_setup_paddr", 64'(apb.paddr), 64'h1A10_2000);
    cy(); #1;
    chk("t2_w1_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); #1;
    chk("t2_w2_addr_data", {apb.paddr, apb.pwdata}, 64'h1A10_2000_1234_5678);
    cy(); #1;
    chk("t2_w3_pwr_sel_en", 64'({apb.pwrite, apb.psel, apb.penable}), 64'h7);
    cy(); apb.pready = 1'b1; apb.pslverr = 1'b1; apb.prdata = 32'hFFFF_FFFF; #1;
    chk("t2_done_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); apb.pready = 1'b0; apb.pslverr = 1'b0; #1;
    chk("t2_rsp_valid", 64'(rsp_valid_o), 64'h2);
    chk("t2_err", 64'(rsp_err_o), 64'h1);
    chk("t2_rdata_zero", 64'(rsp_rdata_o), 64'h0);

    // Both requesters held after reset: grants alternate 0,1,0,1.
    cy(); rst = 1'b1;
    cy(); rst = 1'b0; req_i = 2'b11; req_we_i = 2'b00;
    req_addr_i = {32'h1A10_0004, 32'h1A10_0000};
    apb.pready = 1'b1; apb.prdata = 32'h1111_0000;
    for (int t = 0; t < 4; t++) begin
      #1;
      chk($sformatf("t3_gnt%0d", t), 64'(gnt_o), (t % 2) ? 64'h2 : 64'h1);
      if (t > 0) chk($sformatf("t3_rsp%0d", t), 64'(rsp_valid_o), (t % 2) ? 64'h1 : 64'h2);
      cy(); #1;
      chk($sformatf("t3_paddr%0d", t), 64'(apb.paddr), (t % 2) ? 64'h1A10_0004 : 64'h1A10_0000);
      cy();
      if (t == 3) req_i = 2'b00;
      cy();
    end
    #1;
    chk("t3_last_rsp", 64'(rsp_valid_o), 64'h2);
    chk("t3_no_extra_gnt", 64'(gnt_o), 64'h0);

    // Reset during ACCESS drops the transfer.
    cy(); apb.pready = 1'b0; req_i = 2'b10; req_addr_i[63:32] = 32'h1A10_3000; #1;
    chk("t4_gnt", 64'(gnt_o), 64'h2);
    cy(); req_i = 2'b00;
    cy(); #1;
    chk("t4_access_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); rst = 1'b1; #1;
    chk("t4_rst_sel_en", 64'({apb.psel, apb.penable}), 64'h0);
    chk("t4_rst_paddr", 64'(apb.paddr), 64'h0);
    chk("t4_rst_rsp", 64'(rsp_valid_o), 64'h0);
    cy(); rst = 1'b0; #1;
    chk("t4_no_rsp", 64'(rsp_valid_o), 64'h0);
    req_i = 2'b11; #1;
    chk("t4_gnt_after_rst", 64'(gnt_o), 64'h1);
    cy(); req_i = 2'b00; apb.pready = 1'b1; apb.prdata = 32'hCAFE_F00D;
    cy();
    cy(); apb.pready = 1'b0; #1;
    chk("t4_rsp_valid", 64'(rsp_valid_o), 64'h1);
    chk("t4_rdata", 64'(rsp_rdata_o), 64'hCAFE_F00D);

`ifdef APB_ARB_TIMEOUT_EN
    // Timeout after four wait-state ACCESS cycles.
    cy(); req_i = 2'b01; req_addr_i[31:0] = 32'h1A10_4000; req_we_i = 2'b00; #1;
    chk("t5_gnt", 64'(gnt_o), 64'h1);
    cy(); req_i = 2'b00; apb.prdata = 32'hDEAD_BEEF;
    cy(); cy(); cy(); cy(); #1;
    chk("t5_a4_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); #1;
    chk("t5_abort_sel_en", 64'({apb.psel, apb.penable}), 64'h0);
    chk("t5_rsp_valid", 64'(rsp_valid_o), 64'h1);
    chk("t5_err", 64'(rsp_err_o), 64'h1);
    chk("t5_rdata_zero", 64'(rsp_rdata_o), 64'h0);

    // pready on the fourth ACCESS cycle beats the timeout.
    cy(); req_i = 2'b01; #1;
    chk("t6_gnt", 64'(gnt_o), 64'h1);
    cy(); req_i = 2'b00;
    cy(); cy(); cy();
    cy(); apb.pready = 1'b1; apb.prdata = 32'h0BAD_F00D; #1;
    chk("t6_a4_sel_en", 64'({apb.psel, apb.penable}), 64'h3);
    cy(); apb.pready = 1'b0; #1;
    chk("t6_rsp_valid", 64'(rsp_valid_o), 64'h1);
    chk("t6_err", 64'(rsp_err_o), 64'h0);
    chk("t6_rdata", 64'(rsp_rdata_o), 64'h0BAD_F00D);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
